// File: rtl/game_pkg.sv
// Constants shared by the game FSM and the round event generator.
// The state codes here line up with the FSM's IDLE/RUNNING/FINISH encodings.
package game_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_COUNT = COUNT,
        S_DONE  = DONE
    } state_e;

    localparam int         TIME_W        = 6;
    localparam int         LFSR_W        = 8;
    // Galois right-shift mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/round_event_gen_if.sv
// Signals shared between the round event generator and the game FSM / board.
// master drives requests and buttons; slave is the event generator.
interface round_event_gen_if #(
    parameter int NUM_TARGETS = 4
) ();
    import game_pkg::*;

    logic                   startGame;
    logic                   game_active;
    logic [NUM_TARGETS-1:0] buttons;
    logic [NUM_TARGETS-1:0] target;
    logic                   player_scored;
    logic                   miss;
    logic                   timer_expired;
    logic [TIME_W-1:0]      time_left;

    modport master (
        output startGame, game_active, buttons,
        input  target, player_scored, miss, timer_expired, time_left
    );

    modport slave (
        input  startGame, game_active, buttons,
        output target, player_scored, miss, timer_expired, time_left
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a one-cycle rising-edge pulse per bit.
module sync_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/round_event_gen.sv
// Countdown, random target selection and press checking for one game round.
// Produces the player_scored / timer_expired events consumed by the game FSM.
module round_event_gen
    import game_pkg::*;
#(
    parameter int          game_timer  = 30,
    parameter int          NUM_TARGETS = 4,
    parameter logic [7:0]  LFSR_SEED   = LFSR_SEED_DEF
) (
    input  logic              clkIn,
    input  logic              reset,
    input  logic              incrementClk,
    round_event_gen_if.slave  bus
);

    localparam int TW = $clog2(NUM_TARGETS);

    logic                   sec_tick;
    logic [NUM_TARGETS-1:0] press;

    state_e                 state_q, state_d;
    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic [NUM_TARGETS-1:0] target_q, target_d;
    logic [TIME_W-1:0]      time_left_q, time_left_d;
    logic                   scored_q, scored_d;
    logic                   miss_q, miss_d;
    logic                   expired_q, expired_d;

    logic [TW-1:0]          cur_idx;
    logic [TW-1:0]          cand;
    logic [TW-1:0]          pick_idx;
    logic [NUM_TARGETS-1:0] new_target;

    sync_edge_detect #(.WIDTH(1)) u_sec_sync (
        .clk   (clkIn),
        .rst_n (reset),
        .din   (incrementClk),
        .rise  (sec_tick)
    );

    sync_edge_detect #(.WIDTH(NUM_TARGETS)) u_btn_sync (
        .clk   (clkIn),
        .rst_n (reset),
        .din   (bus.buttons),
        .rise  (press)
    );

    // Index of the lit target; an all-zero target encodes as 0.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (target_q[i]) cur_idx = TW'(i);
        end
    end

    // Bumping a collision by one keeps consecutive targets distinct.
    always_comb begin
        cand       = lfsr_q[TW-1:0];
        pick_idx   = (cand == cur_idx) ? cand + TW'(1) : cand;
        new_target = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << pick_idx;
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_step(lfsr_q);
        target_d    = target_q;
        time_left_d = time_left_q;
        scored_d    = 1'b0;
        miss_d      = 1'b0;
        expired_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.startGame) begin
                    state_d     = S_COUNT;
                    time_left_d = TIME_W'(game_timer);
                    target_d    = new_target;
                end
            end
            S_COUNT: begin
                // Expiry takes precedence over any press resolving on the same cycle.
                if (sec_tick && time_left_q == TIME_W'(1)) begin
                    state_d     = S_DONE;
                    time_left_d = '0;
                    target_d    = '0;
                    expired_d   = 1'b1;
                end else begin
                    if (sec_tick) time_left_d = time_left_q - TIME_W'(1);
                    if (bus.game_active && (|press)) begin
                        // target is one-hot here, so equality also rules out multi-press
                        if (press == target_q) begin
                            scored_d = 1'b1;
                            target_d = new_target;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            target_q    <= '0;
            time_left_q <= '0;
            scored_q    <= 1'b0;
            miss_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            target_q    <= target_d;
            time_left_q <= time_left_d;
            scored_q    <= scored_d;
            miss_q      <= miss_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.target        = target_q;
    assign bus.time_left     = time_left_q;
    assign bus.player_scored = scored_q;
    assign bus.miss          = miss_q;
    assign bus.timer_expired = expired_q;

endmodule

// File: tb/tb_round_event_gen.sv
// Directed bench for round_event_gen with game_timer=3 and four targets.
module tb_round_event_gen;

    logic       clkIn = 1'b0;
    logic       reset;
    logic       incrementClk;
    logic [7:0] lfsr_m;
    logic [3:0] exp_tgt;
    int         n_checks = 0;
    int         n_fail   = 0;

    round_event_gen_if #(.NUM_TARGETS(4)) bus ();

    round_event_gen #(
        .game_timer  (3),
        .NUM_TARGETS (4),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clkIn        (clkIn),
        .reset        (reset),
        .incrementClk (incrementClk),
        .bus          (bus)
    );

    always #5 clkIn = ~clkIn;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois, one step per clock
    always @(posedge clkIn or negedge reset) begin
        if (!reset) lfsr_m <= 8'hA5;
        else        lfsr_m <= {1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
    end

    function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] old);
        logic [1:0] oi;
        logic [1:0] c;
        oi = 2'd0;
        for (int i = 0; i < 4; i++) if (old[i]) oi = 2'(i);
        c = l[1:0];
        if (c == oi) c = c + 2'd1;
        return 4'b0001 << c;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic start_game(input string tag);
        logic [3:0] e;
        e = pick(lfsr_m, exp_tgt);
        bus.startGame = 1'b1;
        cyc(1);
        bus.startGame = 1'b0;
        exp_tgt = e;
        n_checks++;
        if (bus.time_left !== 6'd3) begin
            n_fail++; $display("FAIL %s_time_left: got %0d want 3", tag, bus.time_left);
        end
        n_checks++;
        if (bus.target !== e) begin
            n_fail++; $display("FAIL %s_target: got %b want %b", tag, bus.target, e);
        end
        $display("start %s: time_left=%0d target=%b", tag, bus.time_left, bus.target);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.buttons     = 4'(k * 5);
            bus.startGame   = k[0];
            bus.game_active = k[1];
            incrementClk    = k[2];
            cyc(1);
            n_checks++;
            if ({bus.target, bus.time_left, bus.player_scored, bus.miss, bus.timer_expired} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got tgt=%b tl=%0d ps=%b m=%b te=%b want all 0",
                         bus.target, bus.time_left, bus.player_scored, bus.miss, bus.timer_expired);
            end
        end
        bus.buttons = 4'd0; bus.startGame = 1'b0; bus.game_active = 1'b0; incrementClk = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(4);
        n_checks++;
        if ({bus.target, bus.time_left, bus.player_scored, bus.miss, bus.timer_expired} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_release: got tgt=%b tl=%0d want 0 0", bus.target, bus.time_left);
        end
        exp_tgt = 4'd0;
        $display("reset: target=%b time_left=%0d", bus.target, bus.time_left);
    endtask

    task automatic test_countdown;
        int pulses;
        start_game("count");
        bus.game_active = 1'b1;
        for (int k = 2; k >= 1; k--) begin
            incrementClk = 1'b1;
            cyc(2);
            n_checks++;
            if (bus.time_left !== 6'(k + 1)) begin
                n_fail++; $display("FAIL count_early: got %0d want %0d", bus.time_left, k + 1);
            end
            cyc(1);
            n_checks++;
            if (bus.time_left !== 6'(k)) begin
                n_fail++; $display("FAIL count_dec: got %0d want %0d", bus.time_left, k);
            end
            $display("tick: time_left=%0d", bus.time_left);
            incrementClk = 1'b0;
            cyc(3);
        end
        incrementClk = 1'b1;
        cyc(3);
        n_checks++;
        if ({bus.timer_expired, bus.time_left, bus.target} !== {1'b1, 6'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL count_expire: got te=%b tl=%0d tgt=%b want 1 0 0000",
                     bus.timer_expired, bus.time_left, bus.target);
        end
        exp_tgt = 4'd0;
        cyc(1);
        n_checks++;
        if (bus.timer_expired !== 1'b0) begin
            n_fail++; $display("FAIL count_expire_width: got %b want 0", bus.timer_expired);
        end
        $display("expire: time_left=%0d target=%b", bus.time_left, bus.target);
        incrementClk = 1'b0;
        cyc(3);
        incrementClk = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (bus.timer_expired || bus.player_scored || bus.miss || bus.time_left != 6'd0
                || bus.target != 4'd0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL count_fourth_tick: got %0d changes want 0", pulses);
        end
        incrementClk = 1'b0;
        cyc(3);
    endtask

    task automatic test_hit;
        logic [3:0] e;
        bus.game_active = 1'b0;
        start_game("restart");
        bus.game_active = 1'b1;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            bus.buttons = exp_tgt;
            cyc(2);
            e = pick(lfsr_m, exp_tgt);
            cyc(1);
            n_checks++;
            if ({bus.player_scored, bus.miss} !== 2'b10) begin
                n_fail++; $display("FAIL hit_pulse: got ps=%b m=%b want 1 0", bus.player_scored, bus.miss);
            end
            n_checks++;
            if (bus.target !== e) begin
                n_fail++; $display("FAIL hit_new_target: got %b want %b", bus.target, e);
            end
            $display("hit: pressed=%b new target=%b", exp_tgt, bus.target);
            exp_tgt = e;
            cyc(1);
            n_checks++;
            if (bus.player_scored !== 1'b0) begin
                n_fail++; $display("FAIL hit_width: got %b want 0", bus.player_scored);
            end
            bus.buttons = 4'd0;
            cyc(3);
        end
    endtask

    task automatic test_miss;
        bus.buttons = rotl(exp_tgt);
        cyc(3);
        n_checks++;
        if ({bus.player_scored, bus.miss, bus.target} !== {2'b01, exp_tgt}) begin
            n_fail++;
            $display("FAIL miss_wrong: got ps=%b m=%b tgt=%b want 0 1 %b",
                     bus.player_scored, bus.miss, bus.target, exp_tgt);
        end
        cyc(1);
        n_checks++;
        if (bus.miss !== 1'b0) begin
            n_fail++; $display("FAIL miss_width: got %b want 0", bus.miss);
        end
        $display("miss: pressed=%b target=%b", rotl(exp_tgt), bus.target);
        bus.buttons = 4'd0;
        cyc(3);
        bus.buttons = exp_tgt | rotl(exp_tgt);
        cyc(3);
        n_checks++;
        if ({bus.player_scored, bus.miss, bus.target} !== {2'b01, exp_tgt}) begin
            n_fail++;
            $display("FAIL miss_multi: got ps=%b m=%b tgt=%b want 0 1 %b",
                     bus.player_scored, bus.miss, bus.target, exp_tgt);
        end
        $display("multi: pressed=%b target=%b", exp_tgt | rotl(exp_tgt), bus.target);
        bus.buttons = 4'd0;
        cyc(3);
    endtask

    task automatic test_gating;
        int pulses;
        bus.game_active = 1'b0;
        bus.buttons = exp_tgt;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (bus.player_scored || bus.miss) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || bus.target !== exp_tgt) begin
            n_fail++; $display("FAIL gate_inactive: got %0d pulses tgt=%b want 0 %b", pulses, bus.target, exp_tgt);
        end
        $display("gated press: pulses=%0d", pulses);
        bus.buttons = 4'd0;
        cyc(3);
        bus.game_active = 1'b1;
    endtask

    task automatic test_collision;
        int pulses;
        for (int k = 2; k >= 1; k--) begin
            incrementClk = 1'b1;
            cyc(3);
            n_checks++;
            if (bus.time_left !== 6'(k)) begin
                n_fail++; $display("FAIL coll_dec: got %0d want %0d", bus.time_left, k);
            end
            incrementClk = 1'b0;
            cyc(3);
        end
        incrementClk = 1'b1;
        bus.buttons  = exp_tgt;
        cyc(3);
        n_checks++;
        if ({bus.timer_expired, bus.player_scored, bus.miss, bus.time_left, bus.target} !== {3'b100, 6'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL coll_expire: got te=%b ps=%b m=%b tl=%0d tgt=%b want 1 0 0 0 0000",
                     bus.timer_expired, bus.player_scored, bus.miss, bus.time_left, bus.target);
        end
        $display("collision: te=%b ps=%b m=%b", bus.timer_expired, bus.player_scored, bus.miss);
        exp_tgt = 4'd0;
        incrementClk = 1'b0;
        bus.buttons  = 4'd0;
        cyc(3);
        bus.buttons = 4'b0001;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            if (bus.player_scored || bus.miss || bus.time_left != 6'd0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL done_press: got %0d events want 0", pulses);
        end
        bus.buttons = 4'd0;
        cyc(3);
    endtask

    task automatic test_reset_mid;
        int pulses;
        bus.game_active = 1'b0;
        start_game("mid");
        bus.game_active = 1'b1;
        cyc(1);
        bus.buttons = exp_tgt;
        cyc(2);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (bus.player_scored || bus.miss || bus.timer_expired
                || bus.target != 4'd0 || bus.time_left != 6'd0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL reset_mid: got %0d nonzero cycles want 0", pulses);
        end
        $display("reset mid-game: target=%b time_left=%0d", bus.target, bus.time_left);
        bus.buttons = 4'd0;
        bus.game_active = 1'b0;
        exp_tgt = 4'd0;
        reset = 1'b1;
        cyc(3);
        start_game("after_reset");
        cyc(1);
    endtask

    initial begin
        bus.startGame   = 1'b0;
        bus.game_active = 1'b0;
        bus.buttons     = 4'd0;
        incrementClk    = 1'b0;
        exp_tgt         = 4'd0;
        test_reset();
        test_countdown();
        test_hit();
        test_miss();
        test_gating();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_event_gen.md
# round_event_gen

Event generator driving the game FSM's `player_scored` and `timer_expired` inputs. It runs the per-game countdown from the 1 Hz `incrementClk`, lights one of `NUM_TARGETS` target LEDs chosen by a free-running LFSR, and checks synchronized button presses against the lit target. It sits between the board buttons/LEDs and the game FSM, and shares the FSM's `startGame` and `game_active` signals.

## Interface
- `game_timer`, 30: game length in seconds; legal range 1..63.
- `NUM_TARGETS`, 4: number of buttons/LEDs; power of two, 2..8; `TW = log2(NUM_TARGETS)`.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clkIn` in 1: 100 MHz system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low; clears every register.
- `incrementClk` in 1: 1 Hz square wave, asynchronous to `clkIn`; used as data only, never as a clock.
- `startGame` in 1: start request, same signal the FSM receives.
- `game_active` in 1: FSM running flag; gates scoring.
- `buttons` in NUM_TARGETS: raw, already debounced, asynchronous buttons.
- `target` out NUM_TARGETS: one-hot lit target; all zero outside COUNT.
- `player_scored` out 1: single-cycle hit pulse.
- `miss` out 1: single-cycle wrong-press pulse.
- `timer_expired` out 1: single-cycle pulse when the countdown reaches 0.
- `time_left` out 6: seconds remaining, for the display.

## Operation
- Sync front end: `incrementClk` and each `buttons` bit pass through a 2-flop synchronizer, then a registered rising-edge detect. This produces `sec_tick` and `press[NUM_TARGETS-1:0]`, each one cycle wide.
- LFSR: 8-bit Galois LFSR with taps x^8+x^6+x^5+x^4+1. It steps every `clkIn` cycle in all states, so the player's timing supplies entropy.
- Target pick: `cand = lfsr[TW-1:0]`. If `cand` equals the current target index, use `cand+1` (mod NUM_TARGETS). A new target therefore always differs from the old one.

States (2-bit): IDLE=0, COUNT=1, DONE=2. Encoding 3 is illegal and returns to IDLE.
- IDLE or DONE, `startGame`=1 → COUNT. On the same edge: `time_left`<=game_timer; pick a new target.
- COUNT, `sec_tick`, `time_left`>1 → decrement.
- COUNT, `sec_tick`, `time_left`==1 → `time_left`<=0, `timer_expired`<=1 for one cycle, `target`<=0, go to DONE.
- COUNT, `game_active`=1, `press` nonzero:
  - If exactly one bit is set and it equals `target`: `player_scored` pulses and a new target is picked.
  - Otherwise: `miss` pulses and the target is unchanged.
- `startGame` during COUNT is ignored.
- Presses in IDLE/DONE, or in COUNT while `game_active`=0, are discarded with no pulse.
- `sec_tick` and a hit on the same cycle with `time_left`==1: expiry wins; no `player_scored` and no `miss`.
- DONE holds `time_left`=0 until the next `startGame`.

Reset values:
- state=IDLE, `time_left`=0, `target`=0
- `player_scored`=0, `miss`=0, `timer_expired`=0
- lfsr=`LFSR_SEED`, synchronizer and edge flops=0

A reset asserted mid-game clears everything immediately, with no pulse emitted.

## Timing
- All outputs are registered.
- Button rise to `player_scored`/`miss` is 3 `clkIn` edges: sync1, sync2, then edge+decision.
- `incrementClk` rise to `time_left` decrement, or to the `timer_expired` pulse, is 3 edges.
- `startGame` sampled high at edge N:
  - `time_left`=game_timer and `target` nonzero after edge N.
  - First decrement no earlier than the first `sec_tick` after edge N, so the first second may be short.
- The FSM raises `game_active` one cycle after `startGame`. A press resolving on the first COUNT cycle is therefore discarded.
- Pulses are exactly 1 cycle. Two pulses on consecutive cycles are legal (e.g. miss then hit).

## Structure
- Shared package `game_pkg`:
  - State localparams IDLE/COUNT/DONE. These values match the game FSM's IDLE/RUNNING/FINISH encodings.
  - LFSR tap mask and default seed.
  - `TIME_W`=6.
- Sub-module `sync_edge_detect #(WIDTH)`: 2-flop synchronizer plus rising-edge pulse, async active-low reset. It is instantiated twice: WIDTH=1 for `incrementClk`, WIDTH=NUM_TARGETS for `buttons`.
- Top level: LFSR, target register, countdown, state machine.

## Test plan
- Reset: hold `reset`=0 with all inputs toggling → all outputs 0 and `time_left`=0; after release, state is IDLE and `target`=0.
- Countdown, game_timer=3: pulse `startGame` and give 3 `incrementClk` rises.
  - `time_left` goes 3→2→1→0.
  - One `timer_expired` pulse arrives 3 edges after the third rise.
  - `target` then goes to 0, and a 4th rise changes nothing.
- Hit: in COUNT with `game_active`=1 and `target`=4'b0100, raise `buttons[2]` → `player_scored`=1 for one cycle 3 edges later; the new `target` is one-hot and ≠4'b0100.
- Miss and multi-press: with `target`=4'b0001:
  - Raise `buttons[3]` → `miss` pulse, target unchanged.
  - Raise `buttons[0]` and `buttons[1]` on the same cycle → `miss`, no score.
- Expiry collision: with `time_left`=1, make a correct press and an `incrementClk` rise resolve on the same cycle → `timer_expired`=1, `player_scored`=0, state DONE.
- Restart and gating:
  - In DONE, pulse `startGame` → `time_left`=game_timer and target nonzero.
  - A press while `game_active`=0 gives no pulse.
  - Asserting `reset` mid-COUNT clears everything with no pulse.
